// File: rtl/comm_pkg.sv
// Shared constants and types for the req/ack link scoreboard.
package comm_pkg;

    localparam int B_DEF       = 16;
    localparam int DEPTH_DEF   = 8;
    localparam int CW_DEF      = 16;
    localparam int NW_DEF      = 16;
    localparam int SYNC_STAGES = 2;

    // Queue entry at the default widths: the expected word plus the cycle it was accepted.
    typedef struct packed {
        logic [B_DEF-1:0]  data;
        logic [CW_DEF-1:0] stamp;
    } q_entry_t;

endpackage

// File: rtl/ack_edge_sync.sv
// Brings an asynchronous ack into the clk domain and flags its rising edge.
// The falling half of the 4-phase handshake produces no event.
module ack_edge_sync
    import comm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Rise event is a function of flops only, so it is glitch-free.
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/comm_scoreboard.sv
// On-chip scoreboard for one 4-phase req/ack link: queues accepted words with
// a timestamp and checks each delivered word against the oldest expected one.
module comm_scoreboard
    import comm_pkg::*;
#(
    parameter int B     = B_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = CW_DEF,
    parameter int NW    = NW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_ack,
    input  logic [B-1:0]             in_data,
    input  logic                     out_ack,
    input  logic [B-1:0]             out_data,
    output logic [NW-1:0]            match_cnt,
    output logic [NW-1:0]            err_cnt,
    output logic                     err_pulse,
    output logic [CW-1:0]            last_lat,
    output logic [CW-1:0]            max_lat,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [B-1:0]  data;
        logic [CW-1:0] stamp;
    } ent_t;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] r_ts;
    ent_t          r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;

    logic [PW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    ent_t          w_head;

    logic          w_cmp_valid;
    logic          w_cmp_eq;
    logic [CW-1:0] w_lat;
    logic          w_wr_en;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic          w_ovf;
    logic          w_unf;

    ack_edge_sync u_in_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (in_ack),
        .o_rise  (w_push)
    );

    ack_edge_sync u_out_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (out_ack),
        .o_rise  (w_pop)
    );

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count = r_wptr - r_rptr;
    assign w_empty = (w_count == {PW{1'b0}});
    assign w_full  = (w_count == PW'(DEPTH));
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    // Decide push/pop/bypass action and the comparison for this cycle.
    always_comb begin
        w_cmp_valid = 1'b0;
        w_cmp_eq    = 1'b0;
        w_lat       = {CW{1'b0}};
        w_wr_en     = 1'b0;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        if (w_pop) begin
            if (!w_empty) begin
                // Pop the head; a simultaneous push refills the freed slot, even when full.
                w_cmp_valid = 1'b1;
                w_cmp_eq    = (out_data == w_head.data);
                w_lat       = r_ts - w_head.stamp;
                w_rptr_nxt  = r_rptr + PW'(1);
                if (w_push) begin
                    w_wr_en    = 1'b1;
                    w_wptr_nxt = r_wptr + PW'(1);
                end else begin
                    w_wr_en    = 1'b0;
                end
            end else if (w_push) begin
                // Bypass: the word being accepted is the one being delivered.
                w_cmp_valid = 1'b1;
                w_cmp_eq    = (out_data == in_data);
                w_lat       = {CW{1'b0}};
            end else begin
                w_unf = 1'b1;
            end
        end else if (w_push) begin
            if (w_full) begin
                w_ovf = 1'b1;
            end else begin
                w_wr_en    = 1'b1;
                w_wptr_nxt = r_wptr + PW'(1);
            end
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Free-running timestamp and queue pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts   <= {CW{1'b0}};
            r_wptr <= {PW{1'b0}};
            r_rptr <= {PW{1'b0}};
        end else begin
            r_ts   <= r_ts + CW'(1);
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
        end
    end

    // Queue storage write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{data: {B{1'b0}}, stamp: {CW{1'b0}}};
            end
        end else if (w_wr_en) begin
            r_mem[r_wptr[AW-1:0]] <= '{data: in_data, stamp: r_ts};
        end
    end

    // Registered result counters, latency statistics and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= {NW{1'b0}};
            err_cnt   <= {NW{1'b0}};
            err_pulse <= 1'b0;
            last_lat  <= {CW{1'b0}};
            max_lat   <= {CW{1'b0}};
            pending   <= {PW{1'b0}};
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pending   <= w_wptr_nxt - w_rptr_nxt;
            overflow  <= overflow | w_ovf;
            underflow <= underflow | w_unf;
            if (w_cmp_valid) begin
                err_pulse <= ~w_cmp_eq;
                last_lat  <= w_lat;
                if (w_lat > max_lat) begin
                    max_lat <= w_lat;
                end
                if (w_cmp_eq) begin
                    if (match_cnt != {NW{1'b1}}) begin
                        match_cnt <= match_cnt + NW'(1);
                    end
                end else begin
                    if (err_cnt != {NW{1'b1}}) begin
                        err_cnt <= err_cnt + NW'(1);
                    end
                end
            end else begin
                err_pulse <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_comm_scoreboard.sv
// Directed bench for comm_scoreboard with hand-computed expectations.
module tb_comm_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        in_ack;
    logic [15:0] in_data;
    logic        out_ack;
    logic [15:0] out_data;
    logic [15:0] match_cnt;
    logic [15:0] err_cnt;
    logic        err_pulse;
    logic [15:0] last_lat;
    logic [15:0] max_lat;
    logic [3:0]  pending;
    logic        overflow;
    logic        underflow;

    int n_chk;
    int n_pass;
    int n_pulse;
    int p0;

    comm_scoreboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ack    (in_ack),
        .in_data   (in_data),
        .out_ack   (out_ack),
        .out_data  (out_data),
        .match_cnt (match_cnt),
        .err_cnt   (err_cnt),
        .err_pulse (err_pulse),
        .last_lat  (last_lat),
        .max_lat   (max_lat),
        .pending   (pending),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count error pulses away from the active edge.
    always @(negedge clk) begin
        if (err_pulse) n_pulse = n_pulse + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        @(negedge clk);
        in_data = d;
        in_ack  = 1'b1;
        repeat (4) @(negedge clk);
        in_ack  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic deliver(input logic [15:0] d);
        @(negedge clk);
        out_data = d;
        out_ack  = 1'b1;
        repeat (4) @(negedge clk);
        out_ack  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        in_ack  = 1'b0;
        out_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_pulse = 0; p0 = 0;
        rst_n = 1'b0; in_ack = 1'b0; out_ack = 1'b0;
        in_data = 16'h0000; out_data = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_match", 32'(match_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_flags", {29'd0, overflow, underflow, err_pulse}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, delivered 10 cycles after it was sent.
        send(16'h1234);
        chk("t1_pend_mid", 32'(pending), 32'd1);
        @(negedge clk);
        deliver(16'h1234);
        chk("t1_match", 32'(match_cnt), 32'd1);
        chk("t1_err", 32'(err_cnt), 32'd0);
        chk("t1_lat", 32'(last_lat), 32'd10);
        chk("t1_max", 32'(max_lat), 32'd10);
        chk("t1_pend", 32'(pending), 32'd0);

        // Three words, middle delivery corrupted; sends 9 cycles apart, latency 27.
        do_reset();
        p0 = n_pulse;
        send(16'h0001); send(16'h0002); send(16'h0003);
        chk("t2_pend3", 32'(pending), 32'd3);
        deliver(16'h0001);
        chk("t2_pulse_d1", 32'(n_pulse - p0), 32'd0);
        deliver(16'h0005);
        chk("t2_pulse_d2", 32'(n_pulse - p0), 32'd1);
        deliver(16'h0003);
        chk("t2_pulse_d3", 32'(n_pulse - p0), 32'd1);
        chk("t2_match", 32'(match_cnt), 32'd2);
        chk("t2_err", 32'(err_cnt), 32'd1);
        chk("t2_lat", 32'(last_lat), 32'd27);
        chk("t2_pend", 32'(pending), 32'd0);

        // Overfill: 9 sends into 8 slots, then drain the first 8.
        do_reset();
        for (int i = 1; i <= 9; i++) send(16'(i));
        chk("t3_pend_full", 32'(pending), 32'd8);
        chk("t3_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) deliver(16'(i));
        chk("t3_match", 32'(match_cnt), 32'd8);
        chk("t3_err", 32'(err_cnt), 32'd0);
        chk("t3_pend", 32'(pending), 32'd0);
        chk("t3_lat", 32'(last_lat), 32'd81);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        chk("t3_unf", 32'(underflow), 32'd0);

        // Delivery with nothing expected.
        do_reset();
        deliver(16'hBEEF);
        chk("t4_unf", 32'(underflow), 32'd1);
        chk("t4_match", 32'(match_cnt), 32'd0);
        chk("t4_err", 32'(err_cnt), 32'd0);
        chk("t4_pend", 32'(pending), 32'd0);

        // Simultaneous push and pop on an empty queue.
        do_reset();
        @(negedge clk);
        in_data = 16'h00AA; out_data = 16'h00AA;
        in_ack = 1'b1; out_ack = 1'b1;
        repeat (4) @(negedge clk);
        in_ack = 1'b0; out_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_match", 32'(match_cnt), 32'd1);
        chk("t5_lat", 32'(last_lat), 32'd0);
        chk("t5_pend", 32'(pending), 32'd0);
        chk("t5_unf", 32'(underflow), 32'd0);

        // Reset in the middle of a handshake.
        do_reset();
        send(16'h0011); send(16'h0022); send(16'h0033);
        chk("t6_pend3", 32'(pending), 32'd3);
        @(negedge clk);
        in_data = 16'h0077;
        in_ack  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pend", 32'(pending), 32'd0);
        chk("t6_rst_cnts", 32'(match_cnt) + 32'(err_cnt) + 32'(last_lat) + 32'(max_lat), 32'd0);
        chk("t6_rst_flags", {29'd0, overflow, underflow, err_pulse}, 32'd0);
        in_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'h0042);
        deliver(16'h0042);
        chk("t6_match", 32'(match_cnt), 32'd1);
        chk("t6_err", 32'(err_cnt), 32'd0);
        chk("t6_pend", 32'(pending), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/comm_scoreboard.md
Name: comm_scoreboard

Overview:
- Synthesizable, self-checking monitor for one asynchronous 4-phase req/ack link. It captures each word accepted on the sender side (in_req/in_ack) and each word delivered on the receiver side (out_req/out_ack).
- Sent words queue in order with a timestamp. Each delivered word is compared against the queue head.
- Reports match/error counts, per-transfer latency and maximum latency, plus sticky overflow/underflow flags.
- Sits alongside the handshake channel in bench and FPGA builds. It replaces file-based logging with on-chip checking.

Parameters:
- B, 16, data width of both links
- DEPTH, 8, expected-word queue depth (power of 2, >=2)
- CW, 16, width of cycle timestamp and latency values
- NW, 16, width of match/error counters

Ports:
- clk  in  1  monitor clock
- rst_n  in  1  asynchronous active-low reset
- in_ack  in  1  sender-side ack (asynchronous)
- in_data  in  B  sender-side data
- out_ack  in  1  receiver-side ack (asynchronous)
- out_data  in  B  receiver-side data
- match_cnt  out  NW  count of correct deliveries
- err_cnt  out  NW  count of mismatched deliveries
- err_pulse  out  1  one-cycle pulse on mismatch
- last_lat  out  CW  latency of most recent delivery, in cycles
- max_lat  out  CW  maximum latency since reset
- pending  out  log2(DEPTH)+1  words sent but not yet delivered
- overflow  out  1  sticky: push while full
- underflow  out  1  sticky: delivery with nothing expected

Behaviour:
- Reset (rst_n low, async): all outputs 0; queue empty; timestamp counter 0; synchronizer flops 0.
- Timestamp: free-running CW-bit counter, +1 per clk, wraps.
- Each ack passes through a 2-flop synchronizer. An edge detector on the synchronized value produces a 1-cycle event on the 0->1 transition only; the 1->0 transition is ignored.
- Push (in_ack rise event): the {in_data, timestamp} sampled that cycle are written to the queue.
  - Data on each link must remain stable >=3 clk after its ack rises. This is a protocol requirement on the channel.
- Pop (out_ack rise event), queue non-empty:
  - Compare out_data with the head word.
  - Equal: match_cnt+1.
  - Unequal: err_cnt+1 and err_pulse=1 next cycle.
  - last_lat = timestamp - head stamp, mod 2^CW, registered the cycle after the event.
  - max_lat = max(max_lat, new latency).
- Pop with queue empty and no push the same cycle: underflow=1 sticky. No count changes.
- Push and pop in the same cycle, queue empty: bypass. out_data is compared with in_data, latency 0, and the queue stays empty.
- Push and pop in the same cycle, queue non-empty: pop the head, write the new word; pending unchanged. This is legal even when full.
- Push while full with no pop: the word is dropped and overflow=1 sticky.
- Counters saturate at 2^NW-1; no wrap.
- Latency >= 2^CW cycles aliases by design.
- Output latency from ack rise to counter/flag update: 3 clk (2 sync + 1 register).
- rst_n asserted mid-transfer: immediate clear; the partially observed handshake is discarded.
- Fully synchronous apart from the synchronizers and async reset; no latches.

Decomposition:
- Package comm_pkg holds:
  - default B/DEPTH/CW/NW constants
  - SYNC_STAGES = 2
  - typedef of the queue entry struct {data[B], stamp[CW]}
- Sub-module ack_edge_sync: 2-flop synchronizer plus rise detector. It is instantiated twice.
- The queue is inline: circular buffer with pointers of log2(DEPTH)+1 bits.

Test Plan:
- Reset, then send 0x1234 and deliver 0x1234 10 cycles later -> match_cnt=1, err_cnt=0, last_lat=10, pending returns to 0.
- Send 0x0001, 0x0002, 0x0003; deliver 0x0001, 0x0005, 0x0003 -> match_cnt=2, err_cnt=1, exactly one err_pulse, on the second delivery.
- Send 9 words with DEPTH=8 and no deliveries -> pending=8, overflow=1. Delivering 8 words then gives 8 matches of the first 8 words.
- Deliver 0xBEEF with nothing sent -> underflow=1, match_cnt=0, err_cnt=0.
- Drive in_ack and out_ack rising in the same clk on an empty queue with equal data 0x00AA -> match_cnt=1, last_lat=0, pending=0.
- With pending=3, pulse rst_n low mid-handshake -> all outputs 0 immediately. After release, a fresh send/deliver of 0x0042 gives match_cnt=1.
